arith_port_unit: RTL

Sequential arithmetic stage that consumes operands and an operation code from `my_package` (`op_list`, `port_t`) and produces the 10-bit result `m`. It sits directly downstream of the operand formatter, behind a valid/ready handshake, and feeds the result writer through a second valid/ready handshake. ADD and SUB complete in one cycle. An optional iterative shift-add MUL is compiled in by macro.

---
 rtl/arith_port_unit_pkg.sv | 29 ++
 rtl/arith_port_unit_shift_mul.sv | 54 +++++
 rtl/arith_port_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/arith_port_unit_pkg.sv
// Shared types for the arithmetic port stage.
// ARITH_PORT_UNIT_MUL_EN adds the MUL op code.
package my_package;

  localparam int ARITH_A_W = 5;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1
`ifdef ARITH_PORT_UNIT_MUL_EN
    ,
    MUL = 3'd2
`endif
  } op_list;

  typedef struct packed {
    op_list                   op;
    logic [ARITH_A_W-1:0]     a;
    logic [ARITH_A_W-1:0]     b;
    logic [2*ARITH_A_W-1:0]   m;
  } port_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } arith_state_t;

endpackage

// File: rtl/arith_port_unit_shift_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Compiled only when ARITH_PORT_UNIT_MUL_EN is defined.
`ifdef ARITH_PORT_UNIT_MUL_EN
module arith_shift_mul
  import my_package::*;
#(
  parameter int A_W = ARITH_A_W,
  parameter int M_W = 2 * A_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [A_W-1:0] b,
  output logic           done,
  output logic [M_W-1:0] m
);

  localparam logic [2:0] LAST = 3'(A_W - 1);

  logic           busy;
  logic [2:0]     cnt;
  logic [M_W-1:0] mcand;
  logic [M_W-1:0] acc;
  logic [A_W-1:0] mplier;

  // m is the accumulator after the current iteration
  assign m    = mplier[0] ? acc + mcand : acc;
  assign done = busy && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= M_W'(a);
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= m;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= done ? 3'd0 : cnt + 3'd1;
      busy   <= !done;
    end
  end

endmodule
`endif

// File: rtl/arith_port_unit.sv
// Handshaked ADD/SUB stage with registered result and error flag.
// ARITH_PORT_UNIT_MUL_EN adds an iterative MUL through a CALC state.
module arith_port_unit
  import my_package::*;
#(
  parameter int A_W = ARITH_A_W,
  parameter int M_W = 2 * A_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  op_list         in_op,
  input  logic [A_W-1:0] in_a,
  input  logic [A_W-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M_W-1:0] out_m,
  output logic           out_err
);

  arith_state_t   state, state_nxt;
  logic           in_fire;
  logic           is_mul;
  logic           mul_done;
  logic [M_W-1:0] mul_m;
  logic [M_W-1:0] res_m;
  logic           res_err;

  assign in_ready  = (state == IDLE) && !rst;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state == DONE);

`ifdef ARITH_PORT_UNIT_MUL_EN
  assign is_mul = (in_op == MUL);

  arith_shift_mul #(
    .A_W (A_W),
    .M_W (M_W)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (in_fire && is_mul),
    .a     (in_a),
    .b     (in_b),
    .done  (mul_done),
    .m     (mul_m)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_m    = '0;
`endif

  always_comb begin
    res_m   = '0;
    res_err = 1'b0;
    case (in_op)
      ADD: res_m = M_W'(in_a) + M_W'(in_b);
      SUB: res_m = M_W'(in_a) - M_W'(in_b);
`ifdef ARITH_PORT_UNIT_MUL_EN
      MUL: res_m = '0;
`endif
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_fire) state_nxt = is_mul ? CALC : DONE;
      CALC: if (mul_done) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_m   <= '0;
      out_err <= 1'b0;
    end else if (in_fire) begin
      out_m   <= res_m;
      out_err <= res_err;
    end else if (state == CALC && mul_done) begin
      out_m   <= mul_m;
    end
  end

endmodule
